// File: rtl/if_stage_pkg.sv
// Shared widths, opcode constants, FSM encoding and small helpers for the
// instruction-fetch stage.
package if_stage_pkg;

    localparam int AddressBus = 32;
    localparam int InstBus    = 32;
    localparam int StallBus   = 6;

    // Bit of the ctrl stall bus that holds the fetch stage.
    localparam int STALL_IF_BIT = 1;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_MISS = 2'd1,
        IF_RESP = 2'd2
    } if_state_e;

    // Sign-extended B-type immediate (imm[12:1], imm[0] = 0).
    function automatic logic [AddressBus-1:0] b_imm(input logic [InstBus-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // 2-bit saturating counter step toward the observed outcome.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line. Lookup is
// combinational; fills are written on the clock edge. Only the valid bits are
// reset, so a reset invalidates every line without touching tag/data storage.
module if_stage_icache
    import if_stage_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AddressBus-1:0] lookup_addr,
    output logic                  hit,
    output logic [InstBus-1:0]    rdata,
    input  logic                  fill_en,
    input  logic [AddressBus-1:0] fill_addr,
    input  logic [InstBus-1:0]    fill_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = AddressBus - IDX_W - 2;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   valid_d;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [InstBus-1:0] data_mem [LINES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             unused_addr_bits;

    assign lookup_idx = lookup_addr[IDX_W+1:2];
    assign lookup_tag = lookup_addr[AddressBus-1:IDX_W+2];
    assign fill_idx   = fill_addr[IDX_W+1:2];
    assign fill_tag   = fill_addr[AddressBus-1:IDX_W+2];

    // Byte offset never participates in the lookup.
    assign unused_addr_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

    // Zero-cycle hit: valid bit plus tag compare on the current PC.
    assign hit   = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign rdata = data_mem[lookup_idx];

    // Mark the filled line valid.
    always_comb begin
        valid_d = valid_q;
        if (fill_en) valid_d[fill_idx] = 1'b1;
    end

    // Valid-bit register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag and data storage, written on fill only.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, direct-mapped icache lookup, miss
// fetch over a req/ack handshake, and 2-bit BHT branch prediction feeding the
// IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int              ICACHE_IDX = 7,
    parameter int              BHT_IDX    = 8,
    parameter logic [31:0]     RESET_PC   = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [StallBus-1:0]   stall_in,
    input  logic                  jump_enable,
    input  logic [AddressBus-1:0] jump_target,
    input  logic                  bht_update_in,
    input  logic [AddressBus-1:0] bht_pc_in,
    input  logic                  bht_taken_in,
    output logic                  mem_req_out,
    output logic [AddressBus-1:0] mem_addr_out,
    input  logic                  mem_ack_in,
    input  logic [InstBus-1:0]    mem_data_in,
    output logic [AddressBus-1:0] pc_out,
    output logic [InstBus-1:0]    inst_out,
    output logic                  branch_taken_out,
    output logic                  stall_req_out
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX;

    if_state_e             state_q,    state_d;
    logic [AddressBus-1:0] pc_q,       pc_d;
    logic                  discard_q,  discard_d;
    logic                  mem_req_q,  mem_req_d;
    logic [AddressBus-1:0] mem_addr_q, mem_addr_d;
    logic [InstBus-1:0]    resp_inst_q, resp_inst_d;

    logic [BHT_ENTRIES-1:0][1:0] bht_q;
    logic [BHT_ENTRIES-1:0][1:0] bht_d;

    logic                  cache_hit;
    logic [InstBus-1:0]    cache_rdata;
    logic                  fill_en;

    logic                  stall_if;
    logic                  inst_valid;
    logic [InstBus-1:0]    inst_word;
    logic                  pred_taken;
    logic [AddressBus-1:0] next_pc;
    logic [AddressBus-1:0] jump_pc;
    logic [AddressBus-1:0] branch_sum;
    logic [BHT_IDX-1:0]    bht_rd_idx;
    logic [BHT_IDX-1:0]    bht_wr_idx;
    logic                  unused_bits;

    assign stall_if   = stall_in[STALL_IF_BIT];
    assign jump_pc    = {jump_target[AddressBus-1:2], 2'b00};
    assign bht_rd_idx = pc_q[BHT_IDX+1:2];
    assign bht_wr_idx = bht_pc_in[BHT_IDX+1:2];

    assign unused_bits = ^{stall_in[StallBus-1:STALL_IF_BIT+1], stall_in[0],
                           jump_target[1:0], bht_pc_in[AddressBus-1:BHT_IDX+2],
                           bht_pc_in[1:0]};

    if_stage_icache #(
        .IDX_W(ICACHE_IDX)
    ) u_icache (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .lookup_addr(pc_q),
        .hit        (cache_hit),
        .rdata      (cache_rdata),
        .fill_en    (fill_en),
        .fill_addr  (mem_addr_q),
        .fill_data  (mem_data_in)
    );

    // Instruction source, validity and branch prediction for the current PC.
    always_comb begin
        inst_word  = (state_q == IF_RESP) ? resp_inst_q : cache_rdata;
        inst_valid = ((state_q == IF_IDLE) && cache_hit) || (state_q == IF_RESP);
        pred_taken = inst_valid && (inst_word[6:0] == OPCODE_BRANCH) && bht_q[bht_rd_idx][1];
        branch_sum = pc_q + b_imm(inst_word);
        next_pc    = pred_taken ? {branch_sum[AddressBus-1:2], 2'b00} : (pc_q + 32'd4);
    end

    assign pc_out           = pc_q;
    assign inst_out         = inst_valid ? inst_word : '0;
    assign branch_taken_out = pred_taken;
    assign stall_req_out    = !inst_valid;
    assign mem_req_out      = mem_req_q;
    assign mem_addr_out     = mem_addr_q;

    // Per-entry BHT next value; the lookup above sees the pre-update counter.
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        assign bht_d[gi] = (rdy_in && bht_update_in && (bht_wr_idx == BHT_IDX'(gi)))
                         ? sat_update(bht_q[gi], bht_taken_in)
                         : bht_q[gi];
    end

    // BHT counters, reset to weakly not-taken.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) bht_q <= {BHT_ENTRIES{2'b01}};
        else         bht_q <= bht_d;
    end

    // Fetch FSM next-state: redirect beats stall beats advance.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        resp_inst_d = resp_inst_q;
        fill_en     = 1'b0;
        if (rdy_in) begin
            case (state_q)
                IF_IDLE: begin
                    if (jump_enable) begin
                        pc_d = jump_pc;
                    end else if (stall_if) begin
                        pc_d = pc_q;
                    end else if (cache_hit) begin
                        pc_d = next_pc;
                    end else begin
                        state_d    = IF_MISS;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
                IF_MISS: begin
                    if (jump_enable) pc_d = jump_pc;
                    if (mem_ack_in) begin
                        // The line is filled even if the word itself is dropped.
                        fill_en   = 1'b1;
                        mem_req_d = 1'b0;
                        if (discard_q || jump_enable) begin
                            discard_d = 1'b0;
                            state_d   = IF_IDLE;
                        end else begin
                            state_d     = IF_RESP;
                            resp_inst_d = mem_data_in;
                        end
                    end else if (jump_enable) begin
                        discard_d = 1'b1;
                    end
                end
                IF_RESP: begin
                    if (jump_enable) begin
                        pc_d    = jump_pc;
                        state_d = IF_IDLE;
                    end else if (!stall_if) begin
                        pc_d    = next_pc;
                        state_d = IF_IDLE;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    // Fetch FSM and handshake registers; reset drops any outstanding request.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            resp_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            resp_inst_q <= resp_inst_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle table of inputs and expected
// outputs, followed by a hand-written asynchronous-reset-mid-miss sequence.
module tb_if_stage;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [5:0]  stall_in;
    logic        jump_enable;
    logic [31:0] jump_target;
    logic        bht_update_in;
    logic [31:0] bht_pc_in;
    logic        bht_taken_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in;
    logic [31:0] mem_data_in;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        branch_taken_out;
    logic        stall_req_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rdy;
        logic        je;
        logic [31:0] jt;
        logic        st;
        logic        ack;
        logic [31:0] dat;
        logic        bu;
        logic [31:0] bpc;
        logic        bt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_bt;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    if_stage dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .stall_in        (stall_in),
        .jump_enable     (jump_enable),
        .jump_target     (jump_target),
        .bht_update_in   (bht_update_in),
        .bht_pc_in       (bht_pc_in),
        .bht_taken_in    (bht_taken_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_data_in     (mem_data_in),
        .pc_out          (pc_out),
        .inst_out        (inst_out),
        .branch_taken_out(branch_taken_out),
        .stall_req_out   (stall_req_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic vec_t mk(input logic rdy, input logic je, input logic [31:0] jt,
                                input logic st, input logic ack, input logic [31:0] dat,
                                input logic bu, input logic [31:0] bpc, input logic bt,
                                input logic er, input logic [31:0] ea, input logic [31:0] ep,
                                input logic [31:0] ei, input logic eb, input logic es);
        vec_t v;
        v.rdy = rdy; v.je = je; v.jt = jt; v.st = st; v.ack = ack; v.dat = dat;
        v.bu = bu; v.bpc = bpc; v.bt = bt;
        v.e_req = er; v.e_addr = ea; v.e_pc = ep; v.e_inst = ei; v.e_bt = eb; v.e_stall = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic er, input logic [31:0] ea,
                             input logic [31:0] ep, input logic [31:0] ei,
                             input logic eb, input logic es);
        check({tag, " mem_req"},  {31'b0, mem_req_out},      {31'b0, er});
        check({tag, " mem_addr"}, mem_addr_out,              ea);
        check({tag, " pc"},       pc_out,                    ep);
        check({tag, " inst"},     inst_out,                  ei);
        check({tag, " bt"},       {31'b0, branch_taken_out}, {31'b0, eb});
        check({tag, " stall"},    {31'b0, stall_req_out},    {31'b0, es});
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; stall_in = '0; jump_enable = 1'b0; jump_target = '0;
        bht_update_in = 1'b0; bht_pc_in = '0; bht_taken_in = 1'b0;
        mem_ack_in = 1'b0; mem_data_in = '0;
    endtask

    initial begin
        //            rdy je jt           st ack dat           bu bpc    bt | req addr         pc           inst         bt st
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h0,       32'h0,       32'h0,       0,1)); // c0 cold miss
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  1,32'h0,       32'h0,       32'h0,       0,1)); // c1 req addr 0
        vecs.push_back(mk(1,0,32'h0,       0,1,32'h13,        0,32'h0, 0,  1,32'h0,       32'h0,       32'h0,       0,1)); // c2 ack
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h0,       32'h0,       32'h13,      0,0)); // c3 resp
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h0,       32'h4,       32'h0,       0,1)); // c4 miss pc4
        vecs.push_back(mk(1,1,32'h0,       0,0,32'h0,         0,32'h0, 0,  1,32'h4,       32'h4,       32'h0,       0,1)); // c5 jump in miss
        vecs.push_back(mk(1,0,32'h0,       0,1,32'hAAAA0013,  0,32'h0, 0,  1,32'h4,       32'h0,       32'h0,       0,1)); // c6 discarded ack
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h4,       32'h0,       32'h13,      0,0)); // c7 refetch hit 0
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h4,       32'h4,       32'hAAAA0013,0,0)); // c8 hit filled line
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h4,       32'h8,       32'h0,       0,1)); // c9 miss pc8
        vecs.push_back(mk(1,1,32'h100,     0,0,32'h0,         0,32'h0, 0,  1,32'h8,       32'h8,       32'h0,       0,1)); // c10 redirect 100
        vecs.push_back(mk(1,0,32'h0,       0,1,32'h00100093,  0,32'h0, 0,  1,32'h8,       32'h100,     32'h0,       0,1)); // c11 stale ack
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h8,       32'h100,     32'h0,       0,1)); // c12 miss 100
        vecs.push_back(mk(1,0,32'h0,       0,1,32'h00200113,  0,32'h0, 0,  1,32'h100,     32'h100,     32'h0,       0,1)); // c13 ack 100
        vecs.push_back(mk(1,1,32'h8,       0,0,32'h0,         0,32'h0, 0,  0,32'h100,     32'h100,     32'h00200113,0,0)); // c14 jump in resp
        vecs.push_back(mk(1,1,32'h23,      0,0,32'h0,         0,32'h0, 0,  0,32'h100,     32'h8,       32'h00100093,0,0)); // c15 hit 8, jump 20
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h100,     32'h20,      32'h0,       0,1)); // c16 miss 20
        vecs.push_back(mk(1,0,32'h0,       0,1,32'hFE000EE3,  0,32'h0, 0,  1,32'h20,      32'h20,      32'h0,       0,1)); // c17 ack beq
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         1,32'h20,1,  0,32'h20,      32'h20,      32'hFE000EE3,0,0)); // c18 untrained, upd
        vecs.push_back(mk(1,1,32'h20,      0,0,32'h0,         1,32'h20,1,  0,32'h20,      32'h24,      32'h0,       0,1)); // c19 pc 24, upd
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h20,      32'hFE000EE3,1,0)); // c20 trained, stall
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h20,      32'hFE000EE3,1,0)); // c21 stall
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h20,      32'hFE000EE3,1,0)); // c22 stall
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h20,      32'hFE000EE3,1,0)); // c23 take branch
        vecs.push_back(mk(1,1,32'h100,     1,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h1C,      32'h0,       0,1)); // c24 jump+stall
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         1,32'h20,0,  0,32'h20,      32'h100,     32'h00200113,0,0)); // c25 dec
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         1,32'h20,0,  0,32'h20,      32'h100,     32'h00200113,0,0)); // c26 dec
        vecs.push_back(mk(1,1,32'h20,      0,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h100,     32'h00200113,0,0)); // c27 jump 20
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         1,32'h20,0,  0,32'h20,      32'h20,      32'hFE000EE3,0,0)); // c28 ctr 01
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         1,32'h20,0,  0,32'h20,      32'h20,      32'hFE000EE3,0,0)); // c29 ctr 00
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         1,32'h20,1,  0,32'h20,      32'h20,      32'hFE000EE3,0,0)); // c30 sat 00
        vecs.push_back(mk(1,0,32'h0,       1,0,32'h0,         1,32'h20,1,  0,32'h20,      32'h20,      32'hFE000EE3,0,0)); // c31 ctr 01
        vecs.push_back(mk(0,0,32'h0,       0,1,32'h0,         1,32'h20,0,  0,32'h20,      32'h20,      32'hFE000EE3,1,0)); // c32 rdy low
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h20,      32'hFE000EE3,1,0)); // c33 frozen ok
        vecs.push_back(mk(1,1,32'hFFFFFFFC,0,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'h1C,      32'h0,       0,1)); // c34 jump top
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'h20,      32'hFFFFFFFC,32'h0,       0,1)); // c35 miss top
        vecs.push_back(mk(1,0,32'h0,       0,1,32'h13,        0,32'h0, 0,  1,32'hFFFFFFFC,32'hFFFFFFFC,32'h0,       0,1)); // c36 ack
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'hFFFFFFFC,32'hFFFFFFFC,32'h13,      0,0)); // c37 wrap
        vecs.push_back(mk(1,0,32'h0,       0,0,32'h0,         0,32'h0, 0,  0,32'hFFFFFFFC,32'h0,       32'h13,      0,0)); // c38 pc 0 hit

        idle_inputs();
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rdy_in        = vecs[i].rdy;
            jump_enable   = vecs[i].je;
            jump_target   = vecs[i].jt;
            stall_in      = {4'b0, vecs[i].st, 1'b0};
            mem_ack_in    = vecs[i].ack;
            mem_data_in   = vecs[i].dat;
            bht_update_in = vecs[i].bu;
            bht_pc_in     = vecs[i].bpc;
            bht_taken_in  = vecs[i].bt;
            #1;
            $display("vec %0d: pc=%h inst=%h req=%b addr=%h bt=%b stall=%b",
                     i, pc_out, inst_out, mem_req_out, mem_addr_out, branch_taken_out, stall_req_out);
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc,
                      vecs[i].e_inst, vecs[i].e_bt, vecs[i].e_stall);
            @(negedge clk_in);
        end

        // Async reset in the middle of a miss, with a stray ack around it.
        idle_inputs();
        jump_enable = 1'b1; jump_target = 32'h40;
        @(negedge clk_in);
        jump_enable = 1'b0;
        @(negedge clk_in);
        #1;
        $display("seq miss40: req=%b addr=%h", mem_req_out, mem_addr_out);
        check("rst_pre req", {31'b0, mem_req_out}, 32'h1);
        check("rst_pre addr", mem_addr_out, 32'h40);
        #1;
        rst_in = 1'b0;
        #1;
        $display("seq reset asserted: req=%b pc=%h stall=%b", mem_req_out, pc_out, stall_req_out);
        check("rst_mid req", {31'b0, mem_req_out}, 32'h0);
        check("rst_mid pc", pc_out, 32'h0);
        check("rst_mid stall", {31'b0, stall_req_out}, 32'h1);
        mem_ack_in = 1'b1; mem_data_in = 32'hDEAD0013;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        $display("seq reset released: req=%b pc=%h inst=%h", mem_req_out, pc_out, inst_out);
        check_all("rst_rel", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_in);
        mem_ack_in = 1'b0;
        #1;
        $display("seq refetch: req=%b addr=%h", mem_req_out, mem_addr_out);
        check_all("rst_refetch", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        mem_ack_in = 1'b1; mem_data_in = 32'h00000033;
        @(negedge clk_in);
        mem_ack_in = 1'b0; mem_data_in = '0;
        #1;
        $display("seq refill: pc=%h inst=%h", pc_out, inst_out);
        check_all("rst_refill", 1'b0, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
        @(negedge clk_in);
        #1;
        $display("seq pc4 after reset: pc=%h stall=%b", pc_out, stall_req_out);
        check_all("rst_line1", 1'b0, 32'h0, 32'h4, 32'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; producer side of the IF/ID pipeline register.
- Holds the PC and looks up a direct-mapped instruction cache.
- On a miss, fetches the word from the memory controller over a req/ack handshake.
- Predicts conditional branches with a 2-bit BHT, presents pc/inst/branch_taken to IF/ID, and raises a stall request while no instruction is valid.

Parameters:
ICACHE_IDX, 7, log2 of icache lines (one 32-bit word per line)
BHT_IDX, 8, log2 of BHT entries (2-bit saturating counters)
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes all state
stall_in  input  6  ctrl stall bus; bit 1 = hold IF
jump_enable  input  1  redirect from EX (mispredict or jump)
jump_target  input  32  redirect PC
bht_update_in  input  1  EX resolved a conditional branch
bht_pc_in  input  32  PC of resolved branch
bht_taken_in  input  1  actual outcome
mem_req_out  output  1  fetch request to memory controller
mem_addr_out  output  32  word-aligned fetch address
mem_ack_in  input  1  one-cycle pulse: mem_data_in valid
mem_data_in  input  32  fetched word
pc_out  output  32  PC to IF/ID
inst_out  output  32  instruction to IF/ID
branch_taken_out  output  1  prediction to IF/ID
stall_req_out  output  1  to ctrl: no valid instruction this cycle

Behaviour:
- Reset (rst_in low, async):
  - pc_reg=RESET_PC; state=IDLE; discard=0; mem_req_out=0; mem_addr_out=0.
  - All icache valid bits and all BHT counters cleared (2'b01, weakly not-taken).
  - Combinational outputs follow from this state.
- Reset mid-miss: outstanding request is dropped; a late mem_ack_in in state IDLE is ignored.
- rdy_in=0: no register, cache or BHT changes.
- States:
  - IDLE: lookup. Hit = valid[idx] and tag match, idx=pc_reg[ICACHE_IDX+1:2], tag=pc_reg[31:ICACHE_IDX+2].
    - Hit: inst valid this cycle (zero-cycle hit).
    - Miss: next state MISS; mem_req_out=1, mem_addr_out=pc_reg registered.
  - MISS: hold mem_req_out/mem_addr_out until mem_ack_in. On ack:
    - Write line (valid, tag, data); mem_req_out=0.
    - If discard=0: go to RESP with data latched.
    - If discard=1: clear discard, go to IDLE.
  - RESP: inst valid from latched word; leave when the instruction is consumed or redirected.
- inst_valid = (IDLE and hit) or RESP.
- stall_req_out = !inst_valid.
- inst_out = fetched word when valid, else 0.
- pc_out = pc_reg; branch_taken_out = predicted taken when valid, else 0.
- Prediction: taken when opcode==7'b1100011 and BHT[pc_reg[BHT_IDX+1:2]][1]==1. Next PC = pc_reg + sign-extended B-immediate (imm[12:1]); otherwise pc_reg+4.
- Consumption: instruction is consumed when inst_valid && !stall_in[1] && !jump_enable. On consume, pc_reg <= next PC; RESP goes to IDLE.
- Priority: jump_enable > stall_in[1] > advance.
  - jump_enable: pc_reg <= jump_target, current instruction dropped.
    - In MISS: discard<=1 (fill still written to cache on ack).
    - In RESP: go to IDLE.
- stall_in[1] with no jump: pc_reg and state held; a MISS request still completes, and its data is held in RESP.
- BHT update on bht_update_in: 2-bit saturating increment if taken, decrement if not; saturates at 3 and at 0. Update is independent of fetch.
- Same-cycle BHT read/write of the same entry: read returns the old value.
- PC arithmetic is modulo 2^32 (wrap at 32'hFFFFFFFC+4 -> 0). pc[1:0] is always 0 (jump_target[1:0] is ignored).

Decomposition:
- Shared defines: AddressBus, InstBus, StallBus widths; OPCODE_BRANCH; state encodings IF_IDLE/IF_MISS/IF_RESP.
- Sub-module icache: tag/valid/data arrays with combinational lookup and synchronous fill port, reset clearing valid bits.
- BHT stays inline.

Test Plan:
- Cold start, RESET_PC=0: mem_req_out=1 with addr 0 on the first cycle after reset. Ack with 32'h00000013 two cycles later -> pc_out=0, inst_out=32'h13, stall_req_out=0; next cycle pc_reg=4, miss to addr 4.
- Refetch of addr 0 after fill (jump_enable to 0): hit in the next cycle, mem_req_out stays 0, stall_req_out=0.
- Redirect during miss: jump_enable with target 32'h100 while MISS for addr 8. Ack data is not output; a new request goes to 32'h100. A later jump back to 8 hits with no mem_req.
- Branch prediction: at pc 32'h20, inst 32'hFE000EE3 (beq, imm -4). Before training -> branch_taken_out=0, next pc 32'h24. After two bht_update_in taken at 32'h20 -> branch_taken_out=1, next pc 32'h1C.
- stall_in[1]=1 for 3 cycles on a hit: pc_out/inst_out stable and pc_reg unchanged. jump_enable asserted together with stall -> pc_reg=jump_target next cycle.
- Async reset asserted mid-MISS, with the ack arriving during/after reset: mem_req_out drops immediately, cache lines all invalid, fetch restarts at RESET_PC, stray ack ignored.
